// File: rtl/fetch_pc_unit.sv
// fetch_pc_unit: multi-cycle instruction fetch and program-counter stage of
// the KGP-RISC core.
//
// Fetches the instruction at pc over a req/ack handshake, holds it in the
// instruction register until the datapath commits, then advances pc using
// the ControlUnit's branch/jump decisions and the ALU flags.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   imem_req/imem_addr    fetch request (held until ack) and address (= pc)
//   imem_rdata/imem_ack   instruction word and accept/data-valid strobe
//   instr, opcode, fn     instruction register and its decoded fields
//   instr_valid           instr holds a fetched, uncommitted instruction
//   commit                datapath done with instr; control inputs sampled
//   branch, brnoeq, gotoreg, onlygoto, call, flag_sel
//                         ControlUnit outputs
//   flags                 {overflow, sign, carry, zero} from the ALU
//   reg_target            register value for gotoreg (ret / jump-register)
//   pc                    current program counter
//   link_addr, link_we    return address captured on call, one-cycle write
//   retired               committed-instruction counter
module fetch_pc_unit #(
  parameter int unsigned       ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_ack,
  output logic [31:0]       instr,
  output logic [5:0]        opcode,
  output logic [5:0]        fn,
  output logic              instr_valid,
  input  logic              commit,
  input  logic              branch,
  input  logic              brnoeq,
  input  logic              gotoreg,
  input  logic              onlygoto,
  input  logic              call,
  input  logic [1:0]        flag_sel,
  input  logic [3:0]        flags,
  input  logic [ADDR_W-1:0] reg_target,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] link_addr,
  output logic              link_we,
  output logic [31:0]       retired
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD
  } state_t;

  state_t state;

  logic [ADDR_W-1:0] seq_pc;
  logic [ADDR_W-1:0] jump_off;
  logic [ADDR_W-1:0] branch_off;
  logic [ADDR_W-1:0] next_pc;
  logic              flag_hit;

  assign imem_addr = pc;
  assign opcode    = instr[31:26];
  assign fn        = instr[5:0];

  // Next-PC selection. brnoeq is only considered when branch is clear so that
  // branch takes priority when the ControlUnit asserts both.
  always_comb begin
    seq_pc     = pc + ADDR_W'(4);
    jump_off   = {{(ADDR_W-26){instr[25]}}, instr[25:0]} << 2;
    branch_off = {{(ADDR_W-16){instr[15]}}, instr[15:0]} << 2;
    flag_hit   = flags[flag_sel];
    next_pc    = seq_pc;
    if (gotoreg) begin
      next_pc = reg_target & ~ADDR_W'(3);
    end else if (onlygoto || call) begin
      next_pc = seq_pc + jump_off;
    end else if (branch) begin
      if (flag_hit) next_pc = seq_pc + branch_off;
    end else if (brnoeq && !flag_hit) begin
      next_pc = seq_pc + branch_off;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pc          <= RESET_PC;
      instr       <= '0;
      link_addr   <= '0;
      retired     <= '0;
      imem_req    <= 1'b0;
      instr_valid <= 1'b0;
      link_we     <= 1'b0;
    end else begin
      link_we <= 1'b0;
      unique case (state)
        IDLE: begin
          state    <= REQ;
          imem_req <= 1'b1;
        end
        REQ: begin
          if (imem_ack) begin
            instr       <= imem_rdata;
            imem_req    <= 1'b0;
            instr_valid <= 1'b1;
            state       <= HOLD;
          end
        end
        HOLD: begin
          if (commit) begin
            pc          <= next_pc;
            retired     <= retired + 32'd1;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            state       <= REQ;
            if (call) begin
              link_addr <= seq_pc;
              link_we   <= 1'b1;
            end
          end
        end
        default: begin
          state       <= IDLE;
          imem_req    <= 1'b0;
          instr_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Testbench for fetch_pc_unit: directed scenarios followed by randomized
// traffic, all checked against a transaction-level reference model.
module tb_fetch_pc_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  fn;
  logic        instr_valid;
  logic        commit;
  logic        branch, brnoeq, gotoreg, onlygoto, call;
  logic [1:0]  flag_sel;
  logic [3:0]  flags;
  logic [31:0] reg_target;
  logic [31:0] pc;
  logic [31:0] link_addr;
  logic        link_we;
  logic [31:0] retired;

  int checks = 0;
  int errors = 0;

  // Reference model state: phase 0 = idle, 1 = fetching, 2 = holding.
  int          m_phase;
  logic [31:0] m_pc, m_ret, m_instr, m_link;
  logic        m_linkwe;

  always #5 clk = ~clk;

  fetch_pc_unit #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .instr(instr), .opcode(opcode), .fn(fn), .instr_valid(instr_valid),
    .commit(commit), .branch(branch), .brnoeq(brnoeq), .gotoreg(gotoreg),
    .onlygoto(onlygoto), .call(call), .flag_sel(flag_sel), .flags(flags),
    .reg_target(reg_target), .pc(pc), .link_addr(link_addr),
    .link_we(link_we), .retired(retired)
  );

  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_next_pc(input logic [31:0] cur,
                                              input logic [31:0] ins);
    logic [31:0] seq;
    int signed   off26, off16;
    bit          f;
    seq   = cur + 32'd4;
    off26 = $signed(ins[25:0]);
    off16 = $signed(ins[15:0]);
    f     = flags[flag_sel];
    if (gotoreg)               return reg_target & 32'hFFFF_FFFC;
    if (onlygoto || call)      return seq + 32'(off26 * 4);
    if (branch)                return f ? seq + 32'(off16 * 4) : seq;
    if (brnoeq && !f)          return seq + 32'(off16 * 4);
    return seq;
  endfunction

  task automatic clear_inputs();
    rst = 0; imem_ack = 0; imem_rdata = '0; commit = 0;
    branch = 0; brnoeq = 0; gotoreg = 0; onlygoto = 0; call = 0;
    flag_sel = 2'b00; flags = 4'b0000; reg_target = '0;
  endtask

  // Advance the model by one clock using the inputs now applied, let the DUT
  // take the same edge, then compare everything observable.
  task automatic step();
    if (rst) begin
      m_phase = 0; m_pc = 0; m_ret = 0; m_instr = 0; m_link = 0; m_linkwe = 0;
    end else begin
      m_linkwe = 0;
      if (m_phase == 0) begin
        m_phase = 1;
      end else if (m_phase == 1) begin
        if (imem_ack) begin
          m_instr = imem_rdata;
          m_phase = 2;
        end
      end else if (commit) begin
        if (call) begin
          m_link   = m_pc + 32'd4;
          m_linkwe = 1;
        end
        m_pc    = ref_next_pc(m_pc, m_instr);
        m_ret   = m_ret + 32'd1;
        m_phase = 1;
      end
    end
    @(negedge clk);
    check_eq("imem_req", 32'(imem_req), 32'(m_phase == 1));
    if (m_phase == 1) check_eq("imem_addr", imem_addr, m_pc);
    check_eq("instr_valid", 32'(instr_valid), 32'(m_phase == 2));
    check_eq("instr", instr, m_instr);
    check_eq("opcode", 32'(opcode), 32'(m_instr >> 26));
    check_eq("fn", 32'(fn), 32'(m_instr & 32'h3F));
    check_eq("pc", pc, m_pc);
    check_eq("retired", retired, m_ret);
    check_eq("link_we", 32'(link_we), 32'(m_linkwe));
    check_eq("link_addr", link_addr, m_link);
  endtask

  // Fetch one word (zero wait states) and commit it with the given controls.
  task automatic exec(input logic [31:0] word, input logic [4:0] ctl,
                      input logic [1:0] fsel, input logic [3:0] flg,
                      input logic [31:0] tgt);
    clear_inputs();
    imem_ack = 1; imem_rdata = word;
    step();
    clear_inputs();
    commit = 1;
    {branch, brnoeq, gotoreg, onlygoto, call} = ctl;
    flag_sel = fsel; flags = flg; reg_target = tgt;
    step();
    clear_inputs();
  endtask

  task automatic jump_to(input logic [31:0] a);
    exec(32'h0, 5'b00100, 2'b00, 4'b0000, a);
  endtask

  initial begin
    clear_inputs();
    m_phase = 0; m_pc = 0; m_ret = 0; m_instr = 0; m_link = 0; m_linkwe = 0;
    @(negedge clk);

    // Reset then sequential fetch/commit.
    rst = 1; step(); step(); rst = 0;
    check_eq("rst_pc", pc, 32'h0);
    step();
    check_eq("t1_req", 32'(imem_req), 32'd1);
    exec(32'h0400_0001, 5'b00000, 2'b00, 4'b0000, 32'h0);
    check_eq("t1_pc", pc, 32'h4);
    check_eq("t1_ret", retired, 32'd1);

    // Conditional branches with a negative offset.
    jump_to(32'h10);
    exec(32'h0000_FFFC, 5'b10000, 2'b00, 4'b0001, 32'h0);
    check_eq("bz_taken", pc, 32'h04);
    jump_to(32'h10);
    exec(32'h0000_FFFC, 5'b10000, 2'b00, 4'b0000, 32'h0);
    check_eq("bz_not_taken", pc, 32'h14);
    jump_to(32'h10);
    exec(32'h0000_FFFC, 5'b01000, 2'b00, 4'b0000, 32'h0);
    check_eq("bnz_taken", pc, 32'h04);
    jump_to(32'h10);
    exec(32'h0000_FFFC, 5'b11000, 2'b00, 4'b0000, 32'h0);
    check_eq("both_branch_wins", pc, 32'h14);

    // Call then return through a misaligned register value.
    jump_to(32'h20);
    exec(32'h0000_0010, 5'b00001, 2'b00, 4'b0000, 32'h0);
    check_eq("call_pc", pc, 32'h64);
    check_eq("call_link", link_addr, 32'h24);
    check_eq("call_we", 32'(link_we), 32'd1);
    step();
    check_eq("call_we_drop", 32'(link_we), 32'd0);
    exec(32'h0, 5'b00100, 2'b00, 4'b0000, 32'h27);
    check_eq("ret_pc", pc, 32'h24);
    check_eq("ret_we", 32'(link_we), 32'd0);

    // Wait states with a stray commit during the request.
    for (int i = 0; i < 3; i++) begin
      commit = (i == 1); step(); commit = 0;
    end
    check_eq("ws_pc", pc, 32'h24);
    imem_ack = 1; imem_rdata = 32'h1234_5678; step(); imem_ack = 0;
    check_eq("ws_valid", 32'(instr_valid), 32'd1);
    commit = 1; step(); commit = 0;

    // Reset while a fetch is outstanding; the late ack must be ignored.
    jump_to(32'h40);
    rst = 1; step(); rst = 0;
    imem_ack = 1; imem_rdata = 32'hDEAD_BEEF; step(); imem_ack = 0;
    check_eq("rst_mid_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_mid_addr", imem_addr, 32'h0);
    check_eq("rst_mid_ret", retired, 32'd0);

    // Sequential wrap at the top of the address space.
    jump_to(32'hFFFF_FFFC);
    exec(32'h0, 5'b00000, 2'b00, 4'b0000, 32'h0);
    check_eq("wrap_pc", pc, 32'h0);
    check_eq("wrap_addr", imem_addr, 32'h0);

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      rst        = ($urandom_range(0, 199) == 0);
      imem_ack   = ($urandom_range(0, 2) == 0);
      imem_rdata = $urandom();
      commit     = ($urandom_range(0, 2) == 0);
      {branch, brnoeq, gotoreg, onlygoto, call} = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 0) begin
        gotoreg = 0;
        if ($urandom_range(0, 1) == 0) begin onlygoto = 0; call = 0; end
      end
      flag_sel   = 2'($urandom_range(0, 3));
      flags      = 4'($urandom_range(0, 15));
      reg_target = $urandom();
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_pc_unit.md
Name: fetch_pc_unit

Overview:
- Multi-cycle instruction fetch and program-counter stage of the KGP-RISC core.
- Fetches from instruction memory over a req/ack handshake and holds the instruction register.
- Presents opcode/fn to the ControlUnit.
- On commit, consumes the ControlUnit's branch, brnoeq, gotoreg, onlygoto, call and flag outputs plus ALU flags to compute the next PC and the call link address.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
ADDR_W, 32, PC/address width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
imem_req  output  1  fetch request, held until ack
imem_addr  output  ADDR_W  fetch address (= pc)
imem_rdata  input  32  instruction word, valid with imem_ack
imem_ack  input  1  memory accepts request / data valid
instr  output  32  instruction register
opcode  output  6  instr[31:26], to ControlUnit.instruction
fn  output  6  instr[5:0], to ControlUnit.fn
instr_valid  output  1  instr holds a fetched, uncommitted instruction
commit  input  1  datapath done with instr; sample control inputs this cycle
branch, brnoeq, gotoreg, onlygoto, call  input  1 each  ControlUnit outputs
flag_sel  input  2  ControlUnit flag: 00 zero, 01 carry, 10 sign, 11 overflow
flags  input  4  {overflow, sign, carry, zero} from ALU flag register
reg_target  input  ADDR_W  register value for gotoreg (ret / jump-register)
pc  output  ADDR_W  current PC
link_addr  output  ADDR_W  pc+4 captured on call
link_we  output  1  one-cycle pulse: write link_addr to ra
retired  output  32  committed-instruction counter

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values:
  - pc = RESET_PC.
  - instr, link_addr, retired = 0.
  - imem_req, instr_valid, link_we = 0.
  - State = IDLE.
- State machine: IDLE -> REQ -> HOLD -> REQ ...
  - IDLE: one cycle after reset release; no outputs asserted; next state REQ.
  - REQ: imem_req=1, imem_addr=pc, both stable until ack. On imem_ack: instr <= imem_rdata, go to HOLD. Zero wait states allowed: ack in the first REQ cycle gives instr_valid on the next cycle.
  - HOLD: instr_valid=1; opcode/fn driven combinationally from instr. On commit: pc <= next_pc, retired <= retired+1 (wraps at 2^32), go to REQ. instr_valid drops the cycle after commit.
- commit outside HOLD is ignored. imem_ack outside REQ is ignored.
- next_pc, first match wins, all arithmetic modulo 2^ADDR_W; seq = pc+4:
  - gotoreg: {reg_target[ADDR_W-1:2], 2'b00}.
  - onlygoto or call: seq + (sext(instr[25:0]) << 2).
  - branch and flags[flag_sel]==1: seq + (sext(instr[15:0]) << 2).
  - brnoeq and flags[flag_sel]==0: same target as branch.
  - Otherwise: seq.
  - branch and brnoeq both set: branch wins.
- call at commit: link_addr <= pc+4 and link_we=1 for exactly the following cycle. call together with gotoreg: link still written, next_pc from gotoreg.
- Wrap-around: pc=32'hFFFF_FFFC with sequential commit gives pc=0.
- rst in any state, including mid-REQ: next cycle is the reset state. Any outstanding request is abandoned; an ack arriving after reset is ignored (state IDLE).

Test Plan:
1. Reset/sequential: rst 2 cycles, release; IDLE 1 cycle, then imem_req=1, imem_addr=0; ack with rdata=32'h0400_0001 -> next cycle instr_valid=1, opcode=6'b000001, fn=6'b000001; commit with all controls 0 -> pc=4, retired=1, imem_req=1 next cycle.
2. bz taken/not taken: pc=0x10, instr[15:0]=16'hFFFC, branch=1, flag_sel=00:
   - flags=4'b0001 -> pc=0x04.
   - flags=4'b0000 -> pc=0x14.
   - brnoeq=1 with flags=4'b0000 -> pc=0x04.
3. Call/ret: pc=0x20, call=1, instr[25:0]=26'h10 -> pc=0x64, link_addr=0x24, link_we high exactly 1 cycle. Then gotoreg=1, reg_target=0x27 -> pc=0x24, link_we stays 0.
4. Wait states: hold imem_ack low 3 cycles -> imem_req and imem_addr stable throughout; commit pulsed during REQ -> pc and retired unchanged; ack on cycle 4 -> instr_valid next cycle.
5. Reset mid-fetch: pc=0x40, in REQ; assert rst one cycle, then ack 1 cycle later -> pc=0, retired=0, instr_valid=0, ack ignored; next fetch at address 0.
6. Wrap: pc=32'hFFFF_FFFC, sequential commit -> pc=0, imem_addr=0. retired=32'hFFFF_FFFF plus a commit -> retired=0.
